hex_display_scheduler: RTL and testbench

Sequences a single shared BCD/hex-to-seven-segment decoder across `NUM_DIGITS` display digits. A multi-digit value is accepted with a load/busy handshake and decoded one digit per clock into a staging buffer. All digit outputs are then committed in one cycle, so the displays never show a partially updated value. The block sits between the counter/arithmetic logic and the board HEX displays, replacing one decoder instance per digit.

---
 rtl/hex_display_scheduler_pkg.sv | 32 +++
 rtl/hex_display_scheduler_bcd.sv | 37 +++
 rtl/hex_display_scheduler.sv | 131 +++++++++++++
 tb/tb_hex_display_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_scheduler_pkg.sv
// Shared definitions for hex_display_scheduler: FSM state encoding, segment
// width, blank code and the active-low gfedcba codes for hex digits 0..F.
package hex_display_scheduler_pkg;

  localparam int unsigned SegW = 7;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StScan   = 2'd1,
    StCommit = 2'd2
  } state_e;

  localparam logic [SegW-1:0] SegBlank = 7'b1111111;

  localparam logic [SegW-1:0] Seg0 = 7'b1000000;
  localparam logic [SegW-1:0] Seg1 = 7'b1111001;
  localparam logic [SegW-1:0] Seg2 = 7'b0100100;
  localparam logic [SegW-1:0] Seg3 = 7'b0110000;
  localparam logic [SegW-1:0] Seg4 = 7'b0011001;
  localparam logic [SegW-1:0] Seg5 = 7'b0010010;
  localparam logic [SegW-1:0] Seg6 = 7'b0000010;
  localparam logic [SegW-1:0] Seg7 = 7'b1111000;
  localparam logic [SegW-1:0] Seg8 = 7'b0000000;
  localparam logic [SegW-1:0] Seg9 = 7'b0011000;
  localparam logic [SegW-1:0] SegA = 7'b0001000;
  localparam logic [SegW-1:0] SegB = 7'b0000011;
  localparam logic [SegW-1:0] SegC = 7'b1000110;
  localparam logic [SegW-1:0] SegD = 7'b0100001;
  localparam logic [SegW-1:0] SegE = 7'b0000110;
  localparam logic [SegW-1:0] SegF = 7'b0001110;

endpackage

// File: rtl/hex_display_scheduler_bcd.sv
// Existing combinational BCDToHex decoder.
// Ports:
//   digit_i [3:0] : hex nibble to decode
//   segs_o  [7:0] : {dp, g..a}, active-low; dp is always off (1)
// Note: this legacy decoder renders 0xB with the same pattern as 8; callers
// that need a distinct 'b' override it.
module hex_display_scheduler_bcd
  import hex_display_scheduler_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [7:0] segs_o
);

  always_comb begin
    segs_o = 8'hff;
    unique case (digit_i)
      4'h0: segs_o = {1'b1, Seg0};
      4'h1: segs_o = {1'b1, Seg1};
      4'h2: segs_o = {1'b1, Seg2};
      4'h3: segs_o = {1'b1, Seg3};
      4'h4: segs_o = {1'b1, Seg4};
      4'h5: segs_o = {1'b1, Seg5};
      4'h6: segs_o = {1'b1, Seg6};
      4'h7: segs_o = {1'b1, Seg7};
      4'h8: segs_o = {1'b1, Seg8};
      4'h9: segs_o = {1'b1, Seg9};
      4'ha: segs_o = {1'b1, SegA};
      4'hb: segs_o = {1'b1, Seg8};
      4'hc: segs_o = {1'b1, SegC};
      4'hd: segs_o = {1'b1, SegD};
      4'he: segs_o = {1'b1, SegE};
      4'hf: segs_o = {1'b1, SegF};
      default: segs_o = 8'hff;
    endcase
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Time-multiplexes one hex-to-seven-segment decoder across NUM_DIGITS digits.
// A value is captured on Load while idle, decoded MSD first into a staging
// buffer (one digit per clock), then all digits are committed to HEX at once.
// Ports:
//   Clock : rising-edge clock
//   Reset : synchronous, active-high
//   Load  : update request, honoured only while idle
//   Value : 4*NUM_DIGITS, digit i in [4i+3:4i]
//   Busy  : high whenever not idle
//   Done  : one-cycle pulse in the cycle the new HEX appears
//   HEX   : 7*NUM_DIGITS active-low segments, digit i in [7i+6:7i] (gfedcba)
// Build option: define HEX_LZ_BLANK_EN to blank leading zeros (digit 0 always shown).
module hex_display_scheduler
  import hex_display_scheduler_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Load,
  input  logic [4*NUM_DIGITS-1:0]      Value,
  output logic                         Busy,
  output logic                         Done,
  output logic [SegW*NUM_DIGITS-1:0]   HEX
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q;
  logic [3:0]      shadow_q  [NUM_DIGITS];
  logic [SegW-1:0] staging_q [NUM_DIGITS];
  logic [SegW-1:0] hex_q     [NUM_DIGITS];
  logic            done_q;

  logic [3:0]      nibble;
  logic [7:0]      dec_raw;
  logic [SegW-1:0] dec_seg;
  logic [SegW-1:0] wr_seg;
  logic            unused_dp;

  assign nibble = shadow_q[idx_q];

  hex_display_scheduler_bcd u_dec (
    .digit_i (nibble),
    .segs_o  (dec_raw)
  );

  // Drop the decimal point and give 0xB its own glyph so it differs from 8.
  assign dec_seg   = (nibble == 4'hb) ? SegB : dec_raw[SegW-1:0];
  assign unused_dp = dec_raw[7];

`ifdef HEX_LZ_BLANK_EN
  logic seen_nz_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      seen_nz_q <= 1'b0;
    end else if (state_q == StIdle && Load) begin
      seen_nz_q <= 1'b0;
    end else if (state_q == StScan && nibble != 4'h0) begin
      seen_nz_q <= 1'b1;
    end
  end

  // Zeros ahead of the first non-zero digit are blanked, except digit 0.
  assign wr_seg = (nibble == 4'h0 && !seen_nz_q && idx_q != '0) ? SegBlank : dec_seg;
`else
  assign wr_seg = dec_seg;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (Load) state_d = StScan;
      StScan:   if (idx_q == '0) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx_q  <= '0;
      done_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i]  <= 4'h0;
        staging_q[i] <= SegBlank;
        hex_q[i]     <= SegBlank;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Load) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
              shadow_q[i] <= Value[4*i +: 4];
            end
            idx_q <= LastIdx;
          end
        end
        StScan: begin
          staging_q[idx_q] <= wr_seg;
          idx_q            <= idx_q - 1'b1;
        end
        StCommit: begin
          hex_q  <= staging_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state_q != StIdle);
  assign Done = done_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex
    assign HEX[SegW*g +: SegW] = hex_q[g];
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
module tb_hex_display_scheduler;

  localparam int N = 6;

  logic          clk;
  logic          rst;
  logic          load;
  logic [4*N-1:0] value;
  logic          busy;
  logic          done;
  logic [7*N-1:0] hex;

  int checks;
  int failures;
  logic [7*N-1:0] cur_hex;

  hex_display_scheduler #(.NUM_DIGITS(N)) dut (
    .Clock (clk),
    .Reset (rst),
    .Load  (load),
    .Value (value),
    .Busy  (busy),
    .Done  (done),
    .HEX   (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0011000;
      4'ha: return 7'b0001000;
      4'hb: return 7'b0000011;
      4'hc: return 7'b1000110;
      4'hd: return 7'b0100001;
      4'he: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [7*N-1:0] exp_hex(input logic [4*N-1:0] v);
    logic [7*N-1:0] r;
    logic [3:0]     nib;
    logic [6:0]     s;
    logic           nz;
    nz = 1'b0;
    r  = '1;
    for (int i = N - 1; i >= 0; i--) begin
      nib = v[4*i +: 4];
      s   = seg_of(nib);
`ifdef HEX_LZ_BLANK_EN
      if (nib == 4'h0 && !nz && i != 0) s = 7'b1111111;
`endif
      if (nib != 4'h0) nz = 1'b1;
      r[7*i +: 7] = s;
    end
    return r;
  endfunction

  // Full load-to-commit sequence with cycle-exact Done/Busy/HEX checks.
  task automatic run_update(input string tag, input logic [4*N-1:0] v);
    logic [7*N-1:0] e;
    e     = exp_hex(v);
    load  = 1'b1;
    value = v;
    step();
    load  = 1'b0;
    value = ~v;  // later Value changes must not matter
    check({tag, "_busy_k"}, 64'(busy), 64'd1);
    for (int j = 1; j <= N; j++) begin
      step();
      check({tag, "_nodone"}, 64'(done), 64'd0);
      check({tag, "_hold"}, 64'(hex), 64'(cur_hex));
    end
    step();
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy0"}, 64'(busy), 64'd0);
    check({tag, "_hex"}, 64'(hex), 64'(e));
    cur_hex = e;
    step();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int dones;
    logic [4*N-1:0] vals [24];
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    load     = 1'b0;
    value    = '0;
    cur_hex  = '1;
    step();
    step();
    rst = 1'b0;
    check("rst_hex", 64'(hex), 64'(42'h3ff_ffff_ffff));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    run_update("v012345", 24'h012345);
`ifndef HEX_LZ_BLANK_EN
    check("v012345_d5", 64'(hex[41:35]), 64'(7'b1000000));
`endif
    check("v012345_d0", 64'(hex[6:0]), 64'(7'b0010010));

    run_update("vabcdef", 24'habcdef);
    check("vabcdef_d4", 64'(hex[34:28]), 64'(7'b0000011));
    check("vabcdef_d0", 64'(hex[6:0]), 64'(7'b0001110));
    check("vabcdef_d5", 64'(hex[41:35]), 64'(7'b0001000));

    // Load during scan must be dropped.
    load  = 1'b1;
    value = 24'h314159;
    step();
    load  = 1'b0;
    step();
    step();
    load  = 1'b1;
    value = 24'h999999;
    step();
    load  = 1'b0;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (done) dones++;
    end
    check("drop_dones", 64'(dones), 64'd1);
    check("drop_hex", 64'(hex), 64'(exp_hex(24'h314159)));
    check("drop_busy", 64'(busy), 64'd0);
    cur_hex = exp_hex(24'h314159);

    // Reset mid-scan aborts with no Done.
    load  = 1'b1;
    value = 24'h876543;
    step();
    load = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_hex", 64'(hex), 64'(42'h3ff_ffff_ffff));
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (done) dones++;
    end
    check("abort_nodone", 64'(dones), 64'd0);
    cur_hex = '1;
    run_update("v000007", 24'h000007);

    run_update("v000120", 24'h000120);
`ifdef HEX_LZ_BLANK_EN
    check("lz_120", 64'(hex),
          64'({7'h7f, 7'h7f, 7'h7f, 7'b1111001, 7'b0100100, 7'b1000000}));
`endif
    run_update("vzero", 24'h000000);
`ifdef HEX_LZ_BLANK_EN
    check("lz_zero", 64'(hex), 64'({35'h7_ffff_ffff, 7'b1000000}));
`endif

    // Load held high: one update every N+2 cycles, each using the value
    // present at its accepting edge.
    for (int c = 0; c < 24; c++) vals[c] = 24'(32'h123456 + c * 32'h010101);
    load = 1'b1;
    for (int c = 0; c < 24; c++) begin
      value = vals[c];
      step();
      check("held_done", 64'(done), 64'((c % 8) == 7));
      if ((c % 8) == 7) check("held_hex", 64'(hex), 64'(exp_hex(vals[c-7])));
    end
    load = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
